mc_control_fsm: RTL
===================

# mc_control_fsm

Multicycle control unit for the MIPS softcore, the sequential successor to the single-cycle main decoder. It steps each instruction through fetch, decode, execute, memory and writeback states, issuing per-state datapath controls. A ready/request handshake lets memory stall any access for an arbitrary number of cycles. Optional BNE support and a sticky illegal-opcode flag extend the single-cycle instruction set.

## Interface
- `EN_BNE`, default 1: when 1, opcode 000101 (BNE) is legal; when 0, it is illegal.
- `ALUOP_W`, default 2: width of `aluop`; must be ≥2; upper bits are driven 0.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `op` in 6: opcode of the instruction register; sampled in DECODE only.
- `mem_ready` in 1: memory completes the current access this cycle.
- `zero` in 1: ALU zero flag; used in BRANCH.
- `mem_req` out 1: memory access requested.
- `iord` out 1: address select; 0 = PC, 1 = ALUOut.
- `irwrite` out 1: load the instruction register.
- `memwrite` out 1: write to memory.
- `regwrite` out 1: register file write enable.
- `regdst` out 1: destination select; 1 = rd, 0 = rt.
- `memtoreg` out 1: write-back source select; 1 = data register.
- `alusrca` out 1: 0 = PC, 1 = rs.
- `alusrcb` out 2: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcwrite` out 1: PC write enable, combined with the branch condition.
- `aluop` out ALUOP_W: 00 = add, 01 = sub, 10 = funct.
- `instr_done` out 1: one-cycle pulse on the last cycle of an instruction.
- `illegal` out 1: sticky; set on an unknown opcode.

## Operation
- One-hot or binary encoding is allowed; the states are FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- Every output is 0 unless listed for the current state.
- FETCH:
  - Drives `mem_req`=1, `alusrcb`=01.
  - `irwrite` and `pcwrite` equal `mem_ready`.
  - Advances to DECODE when `mem_ready`=1; otherwise stays.
- DECODE:
  - Drives `alusrcb`=11.
  - Next state by `op`: 100011 or 101011 → MEMADR; 000000 → EXEC; 000100, or 000101 when EN_BNE=1 → BRANCH; 001000 → ADDIEX; 000010 → JUMP.
  - Any other opcode → HALT.
- MEMADR:
  - Drives `alusrca`=1, `alusrcb`=10.
  - Goes to MEMRD for LW, MEMWR for SW. The opcode is latched in DECODE.
- MEMRD:
  - Drives `mem_req`=1, `iord`=1.
  - Goes to MEMWB when `mem_ready`=1; otherwise waits.
- MEMWB:
  - Drives `regwrite`=1, `memtoreg`=1, regdst=0.
  - Drives `instr_done`=1 and returns to FETCH.
- MEMWR:
  - Drives `mem_req`=1, `iord`=1.
  - `memwrite`=1 for every cycle held in MEMWR.
  - On `mem_ready`, drives `instr_done`=1 and goes to FETCH.
- EXEC: drives `alusrca`=1, `aluop`=10; goes to ALUWB.
- ALUWB: drives `regwrite`=1, `regdst`=1, `instr_done`=1; goes to FETCH.
- BRANCH:
  - Drives `alusrca`=1, `aluop`=01, `pcsrc`=01, `instr_done`=1.
  - `pcwrite` = `zero` for BEQ and `!zero` for BNE.
  - Goes to FETCH.
- ADDIEX: drives `alusrca`=1, `alusrcb`=10; goes to ADDIWB.
- ADDIWB: drives `regwrite`=1, `instr_done`=1; goes to FETCH.
- JUMP: drives `pcsrc`=10, `pcwrite`=1, `instr_done`=1; goes to FETCH.
- HALT:
  - Drives `illegal`=1; all other outputs are 0.
  - Stays in HALT until reset.
- `illegal` is registered. It is set on entry to HALT and cleared only by `rst_n`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State is FETCH and the latched opcode is 0; `illegal`=0.
  - Outputs follow FETCH decode: `mem_req`=1, `alusrcb`=01; `irwrite`/`pcwrite` = `mem_ready`; all others 0.
  - `irwrite`/`pcwrite` are forced 0 while `rst_n`=0.
- Reset asserted in mid-instruction aborts it at once; no write occurs after the asserting edge.
- Minimum cycles with `mem_ready` always 1 (FETCH cycle included):
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3.
  - Each extra wait cycle in FETCH, MEMRD or MEMWR adds exactly 1.
- Outputs are Moore from state, except `irwrite`/`pcwrite` in FETCH, `pcwrite` in BRANCH and `instr_done` in MEMWR, which are combinational on the same-cycle input.
- `op` may change outside DECODE without effect.

## Test plan
- Reset mid-MEMRD with `mem_ready`=0, release → FETCH outputs next cycle: `mem_req`=1, `regwrite`=0, `illegal`=0.
- LW (`op`=100011), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite` high only in cycle 5 with `memtoreg`=1; one `instr_done` pulse.
- SW with `mem_ready` low for 3 cycles in MEMWR → `memwrite` high for 4 consecutive cycles; `instr_done` only on the 4th; `regwrite` never asserted.
- BEQ with `zero`=1, then BNE with `zero`=1 (EN_BNE=1) → `pcwrite`=1 with `pcsrc`=01 for BEQ; `pcwrite`=0 for BNE.
- `op`=000101 with EN_BNE=0, then `op`=111111 → HALT; `illegal`=1 persists with no writes until `rst_n` pulses.
- Back-to-back R-type, ADDI, J, with FETCH wait of 2 cycles → R-type 6 cycles, ADDI 6, J 5; `regdst`=1 only in ALUWB; `pcsrc`=10 in JUMP.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control FSM and the MIPS datapath/memory.
// The master side is the control unit: it drives the datapath controls and
// observes the opcode, the memory ready flag and the ALU zero flag.
interface mc_control_fsm_if #(
    parameter int ALUOP_W = 2
) ();
    logic [5:0]         op;
    logic               mem_ready;
    logic               zero;

    logic               mem_req;
    logic               iord;
    logic               irwrite;
    logic               memwrite;
    logic               regwrite;
    logic               regdst;
    logic               memtoreg;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic               pcwrite;
    logic [ALUOP_W-1:0] aluop;
    logic               instr_done;
    logic               illegal;

    modport master (
        input  op, mem_ready, zero,
        output mem_req, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcwrite, aluop, instr_done, illegal
    );

    modport slave (
        output op, mem_ready, zero,
        input  mem_req, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcwrite, aluop, instr_done, illegal
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: steps each instruction through
// fetch/decode/execute/memory/writeback with a memory ready/request handshake.
// Outputs are decoded from the state register; the only input-dependent terms
// are the FETCH write enables, the BRANCH pcwrite and the MEMWR done pulse.
// ALUOP_W is expected to be at least 2; bits above [1:0] are driven 0.
module mc_control_fsm #(
    parameter bit EN_BNE  = 1'b1,
    parameter int ALUOP_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [ALUOP_W-1:0] aluop_c;

    // Next-state selection; DECODE branches on the live opcode, MEMADR on the latched one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BNE:       state_d = EN_BNE ? S_BRANCH : S_HALT;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register, opcode latch (DECODE only) and the sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'b000000;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= bus.op;
            if (state_d == S_HALT) illegal_q <= 1'b1;
        end
    end

    // Per-state datapath controls; everything defaults to 0.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.pcwrite    = 1'b0;
        bus.instr_done = 1'b0;
        aluop_c        = '0;
        unique case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = 2'b01;
                // Gated by rst_n so no IR/PC write can slip through while in reset.
                bus.irwrite = bus.mem_ready & rst_n;
                bus.pcwrite = bus.mem_ready & rst_n;
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.regwrite   = 1'b1;
                bus.memtoreg   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req    = 1'b1;
                bus.iord       = 1'b1;
                bus.memwrite   = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_EXEC: begin
                bus.alusrca  = 1'b1;
                aluop_c[1:0] = 2'b10;
            end
            S_ALUWB: begin
                bus.regwrite   = 1'b1;
                bus.regdst     = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                aluop_c[1:0]   = 2'b01;
                bus.pcsrc      = 2'b01;
                bus.instr_done = 1'b1;
                // Latched opcode bit 0 distinguishes BNE (000101) from BEQ (000100).
                bus.pcwrite    = op_q[0] ? ~bus.zero : bus.zero;
            end
            S_ADDIWB: begin
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.pcsrc      = 2'b10;
                bus.pcwrite    = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
        bus.aluop   = aluop_c;
        bus.illegal = illegal_q;
    end
endmodule
